// File: rtl/rl_force_collector.sv
// Sink for the range-limited force pipeline: tags each (Fx,Fy,Fz) result with its
// home/neighbour pair by counting, buffers it in a FIFO and pulses done after the sweep drains.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | counting pair results and pushing them into the FIFO
// DRAIN   | last pair seen, waiting for the FIFO to empty
// DONE    | one-cycle done pulse
module rl_force_collector #(
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 9,
    parameter int FIFO_DEPTH      = 64,
    parameter int FIFO_ADDR_WIDTH = 6,
    parameter bit DROP_ZERO       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_fx,
    input  logic [DATA_WIDTH-1:0] in_fy,
    input  logic [DATA_WIDTH-1:0] in_fz,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_fx,
    output logic [DATA_WIDTH-1:0] out_fy,
    output logic [DATA_WIDTH-1:0] out_fz,
    output logic [ID_WIDTH-1:0]   out_home,
    output logic [ID_WIDTH-1:0]   out_nbr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = 2 * ID_WIDTH;
    localparam int EW = 3 * DATA_WIDTH + CW;
    localparam int AW = FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            empty, full, last_one, is_zero;
    logic            push_req, push, pop, drop;
    logic [AW:0]     occ;
    logic [EW-1:0]   head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occ      = wr_ptr_q - rd_ptr_q;
    assign last_one = (occ == {{AW{1'b0}}, 1'b1});

    // Sign bits are ignored so that -0 counts as a zero component.
    assign is_zero  = ~|in_fx[DATA_WIDTH-2:0] & ~|in_fy[DATA_WIDTH-2:0] &
                      ~|in_fz[DATA_WIDTH-2:0];

    assign pop      = !empty && out_ready;
    assign push_req = (state_q == S_COLLECT) && in_valid && !(DROP_ZERO && is_zero);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (drop) ovf_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_COLLECT;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_COLLECT: begin
                // Counter keeps running on dropped entries so later tags stay aligned.
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty || (pop && last_one)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= {in_fx, in_fy, in_fz, cnt_q};
    end

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty;
    assign {out_fx, out_fy, out_fz, out_home, out_nbr} = out_valid ? head : '0;
    assign overflow  = ovf_q;
    assign busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/rl_force_collector.md
# rl_force_collector

Downstream sink for the range-limited force pipeline. Captures each valid (Fx, Fy, Fz) result from the pair-evaluation tile and tags it with the home/neighbour index pair it belongs to. Tags are reconstructed by counting, because the pipeline emits pairs in strict home-major, neighbour-minor order. Results are buffered in a FIFO, drained over a ready/valid port, and a one-cycle done pulse is produced once the full pair sweep has been collected and drained. The pipeline has no backpressure, so overflow is detected and flagged rather than stalled.

## Interface
- DATA_WIDTH, 32, width of each IEEE-754 single force component
- ID_WIDTH, 9, width of home and neighbour index; a sweep is 2^(2*ID_WIDTH) pairs
- FIFO_DEPTH, 64, number of buffered entries
- FIFO_ADDR_WIDTH, 6, log2(FIFO_DEPTH)
- DROP_ZERO, 0, when 1, results with all three components equal to ±0 are counted but not buffered
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- start  in  1  begin a new sweep; honoured only in IDLE
- in_fx, in_fy, in_fz  in  DATA_WIDTH each  force components from the pipeline
- in_valid  in  1  force triple valid this cycle
- out_fx, out_fy, out_fz  out  DATA_WIDTH each  buffered force components
- out_home  out  ID_WIDTH  home index of the head entry
- out_nbr  out  ID_WIDTH  neighbour index of the head entry
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head entry
- overflow  out  1  sticky: at least one result was lost in the current sweep
- busy  out  1  state is COLLECT or DRAIN
- done  out  1  one-cycle pulse at end of sweep

## Operation
- States:
  - IDLE: start=1 → COLLECT. On that edge, clear the pair counter, FIFO pointers and overflow.
  - COLLECT: each in_valid increments an unsigned pair counter, 2*ID_WIDTH bits wide. When the increment wraps the counter to 0 (the last pair), go to DRAIN.
  - DRAIN: when the FIFO is empty (including the cycle a pop empties it, evaluated on registered state), go to DONE.
  - DONE: done=1 for one cycle, then → IDLE.
- Tag for each accepted result: out_home = counter[2*ID_WIDTH-1:ID_WIDTH], out_nbr = counter[ID_WIDTH-1:0], using the counter value before the increment.
- Push rule: push only when state=COLLECT, in_valid=1, and not (DROP_ZERO=1 and in_fx[30:0], in_fy[30:0], in_fz[30:0] all zero). The sign bit is ignored in the zero test.
- Pop rule: pop on out_valid & out_ready.
- Full FIFO, push without pop: the entry is dropped and overflow is set. The counter still increments so later tags stay correct.
- Full FIFO, push and pop in the same cycle: both take effect, occupancy is unchanged, no overflow.
- in_valid outside COLLECT, and start outside IDLE: ignored. No count, no push.
- FIFO storage: width 3*DATA_WIDTH + 2*ID_WIDTH, circular pointers of FIFO_ADDR_WIDTH+1 bits (the extra bit distinguishes full from empty). Head data is show-ahead.

## Timing
- Reset: state=IDLE, counter=0, pointers=0. Outputs: out_valid=0, overflow=0, busy=0, done=0. out_fx/out_fy/out_fz/out_home/out_nbr=0.
- rst has priority over every other input; rst mid-sweep discards all buffered entries.
- start sampled at edge t → busy=1 from t+1. in_valid is counted from edge t+1 onward.
- Push at edge t → out_valid=1 and head data visible from t+1 (1-cycle latency) if the FIFO was empty.
- Pop at edge t → the next entry is visible at t+1; out_valid falls at t+1 if the FIFO becomes empty.
- Last pair accepted at edge t → state=DRAIN at t+1.
- FIFO empty in DRAIN at edge u → done=1 during cycle u+1, busy=0 from u+1; state returns to IDLE at u+2.
- Minimum done latency after the last pair with out_ready held at 1: 2 cycles.

## Test plan
- Reduced sweep, ID_WIDTH=2, DROP_ZERO=0: 16 consecutive in_valid with fx=index, out_ready=1 → 16 outputs in order, tags (0,0),(0,1)…(3,3), overflow=0, one done pulse, busy low afterwards.
- Backpressure, ID_WIDTH=2, FIFO_DEPTH=4, out_ready=0 for the first 6 pushes → entries 4 and 5 dropped, overflow=1. After out_ready=1, outputs are tags (0,0)…(0,3), then (1,2) onward. Done still fires.
- Full with simultaneous push and pop: FIFO held full and out_ready=1 during a push → occupancy stays 4, overflow stays 0.
- DROP_ZERO=1: inputs alternate zero triples and nonzero triples, including fx=32'h80000000 (−0) → only nonzero entries appear, with odd neighbour indices; counter still reaches the end and done fires.
- Gapped input: in_valid toggles randomly, and start is pulsed during COLLECT → the second start is ignored; tags stay contiguous.
- Reset mid-sweep after 7 pushes → out_valid=0 and overflow=0 the next cycle. A new start yields the first tag (0,0).
